// File: rtl/bridge_rom_cram_loader.sv
// bridge_rom_cram_loader
// Accepts 32-bit big-endian bridge writes into a small FIFO and drains each
// entry as two 16-bit req/ack writes (high half first) to the cellular RAM
// controller. Status (overflow, loading, completed-word count) is returned
// on bridge reads.
module bridge_rom_cram_loader #(
    parameter int ADDR_WIDTH = 21,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk_74a,
    input  logic                  reset_n,
    input  logic [31:0]           bridge_addr,
    input  logic                  bridge_wr,
    input  logic [31:0]           bridge_wr_data,
    input  logic                  bridge_rd,
    output logic [31:0]           bridge_rd_data,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic                  mem_ack,
    output logic                  loading,
    output logic                  overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam int WORD_W = ADDR_WIDTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HI,
        ST_LO
    } state_t;

    state_t state;

    // FIFO storage and bookkeeping
    logic [WORD_W-1:0] fifo_word [FIFO_DEPTH];
    logic [31:0]       fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [WORD_W-1:0] in_word;
    logic [WORD_W-1:0] head_word;
    logic [31:0]       head_data;

    // Low halfword of the word currently being written, held for the LO phase
    logic [15:0]       cur_lo;
    logic [23:0]       word_count;

    // Byte address bits outside the halfword window are intentionally dropped
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{bridge_addr[31:ADDR_WIDTH+1], bridge_addr[1:0]};

    assign in_word    = bridge_addr[ADDR_WIDTH:2];
    assign fifo_full  = (occ == OCC_W'(FIFO_DEPTH));
    assign fifo_empty = (occ == '0);
    assign push       = bridge_wr && !fifo_full;
    assign pop        = !fifo_empty &&
                        ((state == ST_IDLE) || ((state == ST_LO) && mem_ack));
    assign head_word  = fifo_word[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];
    assign loading    = !fifo_empty || (state != ST_IDLE);

    // FIFO payload write; contents need no reset since occupancy gates reads
    always_ff @(posedge clk_74a) begin
        if (push) begin
            fifo_word[wr_ptr] <= in_word;
            fifo_data[wr_ptr] <= bridge_wr_data;
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Drain FSM: IDLE -> HI -> LO, chaining straight into HI when more is queued
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cur_lo     <= '0;
            word_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        mem_req   <= 1'b1;
                        mem_addr  <= {head_word, 1'b0};
                        mem_wdata <= head_data[31:16];
                        cur_lo    <= head_data[15:0];
                        state     <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (mem_ack) begin
                        mem_addr  <= {mem_addr[ADDR_WIDTH-1:1], 1'b1};
                        mem_wdata <= cur_lo;
                        state     <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (mem_ack) begin
                        if (word_count != '1) word_count <= word_count + 1'b1;
                        if (!fifo_empty) begin
                            mem_addr  <= {head_word, 1'b0};
                            mem_wdata <= head_data[31:16];
                            cur_lo    <= head_data[15:0];
                            state     <= ST_HI;
                        end else begin
                            mem_req <= 1'b0;
                            state   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overflow: any write that finds the FIFO full is lost
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (bridge_wr && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    // Status readback captured from pre-update state, held until the next read
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            bridge_rd_data <= '0;
        end else if (bridge_rd) begin
            bridge_rd_data <= {overflow, 6'b0, loading, word_count};
        end
    end

endmodule

// File: tb/tb_bridge_rom_cram_loader.sv
// Self-checking bench for bridge_rom_cram_loader: a queue-based reference
// model checked every cycle, directed scenarios with literal expectations,
// then a randomized traffic phase.
module tb_bridge_rom_cram_loader;

    localparam int AW    = 21;
    localparam int DEPTH = 16;

    logic          clk_74a = 1'b0;
    logic          reset_n = 1'b0;
    logic [31:0]   bridge_addr = '0;
    logic          bridge_wr = 1'b0;
    logic [31:0]   bridge_wr_data = '0;
    logic          bridge_rd = 1'b0;
    logic [31:0]   bridge_rd_data;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          mem_ack = 1'b0;
    logic          loading;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    bridge_rom_cram_loader #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_74a        (clk_74a),
        .reset_n        (reset_n),
        .bridge_addr    (bridge_addr),
        .bridge_wr      (bridge_wr),
        .bridge_wr_data (bridge_wr_data),
        .bridge_rd      (bridge_rd),
        .bridge_rd_data (bridge_rd_data),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .loading        (loading),
        .overflow       (overflow)
    );

    always #5 clk_74a = ~clk_74a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned m_qword[$];
    logic [31:0] m_qdata[$];
    bit          m_busy = 0;
    bit          m_half = 0;
    int unsigned m_word = 0;
    logic [31:0] m_data = '0;
    int unsigned m_cnt  = 0;
    bit          m_ovf  = 0;
    logic [31:0] m_rd   = '0;
    int          m_pre;
    bit          m_take;

    always @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            m_qword.delete();
            m_qdata.delete();
            m_busy = 0;
            m_half = 0;
            m_cnt  = 0;
            m_ovf  = 0;
            m_rd   = '0;
        end else begin
            m_pre  = m_qword.size();
            m_take = 0;
            if (bridge_rd)
                m_rd = {m_ovf, 6'b0, ((m_pre != 0) || m_busy), m_cnt[23:0]};
            if (!m_busy) begin
                m_take = (m_pre != 0);
            end else if (mem_ack) begin
                if (!m_half) begin
                    m_half = 1;
                end else begin
                    if (m_cnt < 32'hFFFFFF) m_cnt++;
                    m_busy = 0;
                    m_take = (m_pre != 0);
                end
            end
            if (m_take) begin
                m_word = m_qword.pop_front();
                m_data = m_qdata.pop_front();
                m_busy = 1;
                m_half = 0;
            end
            if (bridge_wr) begin
                if (m_pre == DEPTH) begin
                    m_ovf = 1;
                end else begin
                    m_qword.push_back((bridge_addr >> 2) & ((32'd1 << (AW - 1)) - 1));
                    m_qdata.push_back(bridge_wr_data);
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk_74a) begin
        if (reset_n) begin
            check("mem_req", {31'b0, mem_req}, {31'b0, m_busy});
            if (m_busy) begin
                check("mem_addr", {{(32-AW){1'b0}}, mem_addr}, m_word * 2 + m_half);
                check("mem_wdata", {16'b0, mem_wdata},
                      {16'b0, (m_half ? m_data[15:0] : m_data[31:16])});
            end
            check("loading", {31'b0, loading}, {31'b0, ((m_qword.size() != 0) || m_busy)});
            check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
            check("rd_data", bridge_rd_data, m_rd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clk_74a);
        #1;
    endtask

    task automatic do_reset;
        bridge_wr = 0;
        bridge_rd = 0;
        mem_ack   = 0;
        reset_n   = 0;
        repeat (2) tick();
        reset_n = 1;
        tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bridge_addr    = a;
        bridge_wr_data = d;
        bridge_wr      = 1;
        tick();
        bridge_wr = 0;
    endtask

    task automatic rd_check(input string name, input logic [31:0] exp);
        bridge_rd = 1;
        tick();
        bridge_rd = 0;
        check(name, bridge_rd_data, exp);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (loading && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", {31'b0, loading}, 32'd0);
    endtask

    logic [31:0] rdat;
    int          nreq, first_req, last_req;
    bit          load_s[16];

    initial begin
        // Reset state
        #2;
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_loading", {31'b0, loading}, 32'd0);
        do_reset();
        check("rst_mem_addr", {{(32-AW){1'b0}}, mem_addr}, 32'd0);
        check("rst_rd_data", bridge_rd_data, 32'd0);

        // Single write, latency and halfword split
        wr(32'h0000_0010, 32'hA1B2_C3D4);
        check("t1_loading_n1", {31'b0, loading}, 32'd1);
        check("t1_req_n1", {31'b0, mem_req}, 32'd0);
        tick();
        check("t1_req_n2", {31'b0, mem_req}, 32'd1);
        check("t1_addr_hi", {{(32-AW){1'b0}}, mem_addr}, 32'h8);
        check("t1_data_hi", {16'b0, mem_wdata}, 32'hA1B2);
        mem_ack = 1;
        tick();
        check("t1_addr_lo", {{(32-AW){1'b0}}, mem_addr}, 32'h9);
        check("t1_data_lo", {16'b0, mem_wdata}, 32'hC3D4);
        tick();
        mem_ack = 0;
        check("t1_req_done", {31'b0, mem_req}, 32'd0);
        check("t1_loading_done", {31'b0, loading}, 32'd0);
        rd_check("t1_read", 32'h0000_0001);

        // Wait states in HI
        rdat = $urandom;
        wr(32'h0000_0200, rdat);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t2_req_hold", {31'b0, mem_req}, 32'd1);
            check("t2_addr_hold", {{(32-AW){1'b0}}, mem_addr}, 32'h100);
            check("t2_data_hold", {16'b0, mem_wdata}, {16'b0, rdat[31:16]});
            tick();
        end
        mem_ack = 1;
        tick();
        check("t2_addr_lo", {{(32-AW){1'b0}}, mem_addr}, 32'h101);
        tick();
        mem_ack = 0;
        wait_idle(10);

        // Overflow: 18 writes with ack held low
        do_reset();
        for (int i = 0; i < 18; i++) begin
            bridge_addr    = 32'h1000 + 32'(i) * 4;
            bridge_wr_data = $urandom;
            bridge_wr      = 1;
            tick();
        end
        bridge_wr = 0;
        check("t3_overflow", {31'b0, overflow}, 32'd1);
        mem_ack = 1;
        wait_idle(100);
        mem_ack = 0;
        rd_check("t3_read", 32'h8000_0011);

        // Streaming with ack tied high
        mem_ack   = 1;
        nreq      = 0;
        first_req = -1;
        last_req  = -1;
        for (int k = 0; k < 12; k++) begin
            if (k < 4) begin
                bridge_addr    = 32'h100 + 32'(k) * 4;
                bridge_wr_data = $urandom;
                bridge_wr      = 1;
            end else begin
                bridge_wr = 0;
            end
            tick();
            load_s[k] = loading;
            if (mem_req) begin
                check("t4_addr_order", {{(32-AW){1'b0}}, mem_addr}, 32'h80 + 32'(nreq));
                nreq++;
                if (first_req < 0) first_req = k;
                last_req = k;
            end
        end
        check("t4_req_count", 32'(nreq), 32'd8);
        check("t4_no_gap", 32'(last_req - first_req), 32'd7);
        if (last_req >= 0 && last_req < 11) begin
            check("t4_loading_last", {31'b0, load_s[last_req]}, 32'd1);
            check("t4_loading_fall", {31'b0, load_s[last_req+1]}, 32'd0);
        end else begin
            check("t4_last_req_index", 32'(last_req), 32'd8);
        end
        mem_ack = 0;

        // Reset during LO with 3 entries queued
        do_reset();
        for (int i = 0; i < 4; i++) wr(32'h2000 + 32'(i) * 4, $urandom);
        check("t5_in_hi", {31'b0, mem_req}, 32'd1);
        mem_ack = 1;
        tick();
        mem_ack = 0;
        check("t5_in_lo", {{(32-AW){1'b0}}, mem_addr}, 32'h1001);
        check("t5_loading_pre", {31'b0, loading}, 32'd1);
        #2;
        reset_n = 0;
        #1;
        check("t5_req_rst", {31'b0, mem_req}, 32'd0);
        check("t5_loading_rst", {31'b0, loading}, 32'd0);
        check("t5_count_rst", dut.word_count, 32'd0);
        tick();
        reset_n = 1;
        mem_ack = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5_quiet", {31'b0, mem_req}, 32'd0);
        end
        mem_ack = 0;
        rd_check("t5_read", 32'h0000_0000);

        // Address wrap above ADDR_WIDTH
        mem_ack = 1;
        wr(32'h0080_0004, 32'h1234_5678);
        tick();
        check("t6_addr_hi", {{(32-AW){1'b0}}, mem_addr}, 32'h2);
        check("t6_data_hi", {16'b0, mem_wdata}, 32'h1234);
        tick();
        check("t6_addr_lo", {{(32-AW){1'b0}}, mem_addr}, 32'h3);
        check("t6_data_lo", {16'b0, mem_wdata}, 32'h5678);
        tick();
        mem_ack = 0;
        wait_idle(10);

        // Randomized traffic: slow drain first, then fast drain
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 400; c++) begin
                bridge_wr      = ($urandom_range(0, 99) < 40);
                bridge_addr    = $urandom;
                bridge_wr_data = $urandom;
                bridge_rd      = ($urandom_range(0, 99) < 15);
                mem_ack        = ($urandom_range(0, 99) < (ph == 0 ? 20 : 85));
                tick();
            end
        end
        bridge_wr = 0;
        bridge_rd = 0;
        mem_ack   = 1;
        wait_idle(200);
        mem_ack = 0;
        bridge_rd = 1;
        tick();
        bridge_rd = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
